kgp_multicycle_ctrl: RTL and testbench
======================================

Name: kgp_multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the KGPMini RISC core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALU op code into the ALU control decoder; that decoder combines it with funct to form the 5-bit ALU control.
- Handles the memory-ready handshake, with a timeout counter and a halt/error state.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles spent waiting for mem_ready before trapping to HALT with error. Value 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  opcode field from the instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- ir_write  out  1  load the instruction register
- pc_write  out  1  update PC
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- iord  out  1  0 = memory address from PC, 1 = from ALU result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- alu_op  out  3  op code to the ALU control decoder
- alu_src  out  1  0 = register B, 1 = immediate
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU result
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction
- halted  out  1  FSM is in HALT
- error  out  1  HALT was reached via an illegal opcode or a timeout

Behaviour:
- While rst=1: state<=FETCH, wait_cnt<=0, error<=0. All outputs are forced to 0 combinationally during reset.
- Reset asserted mid-instruction aborts it; no partial reg_write or mem_write is issued.
- Outputs are combinational from the registered state, the opcode, zero and mem_ready. State, wait_cnt and error are registered.
- Opcode map and alu_op:
  - 6'h00 R-type: alu_op=111 (funct selects the operation), alu_src=0
  - 6'h01 ADDI: alu_op=000, alu_src=1
  - 6'h02 COMPI: alu_op=001, alu_src=1
  - 6'h10 LW and 6'h11 SW: alu_op=000, alu_src=1
  - 6'h20 BZ: alu_op=010, alu_src=0
  - 6'h21 BR: no ALU use
  - 6'h3F HALT
  - any other value is illegal
- States are FETCH, DECODE, EXEC, MEM, WB, HALT; state encoding is free.
- FETCH: mem_read=1, iord=0.
  - If mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: no side effects.
  - Next state HALT for 6'h3F (error stays 0).
  - Next state HALT with error<=1 for an illegal opcode.
  - Otherwise next state EXEC.
- EXEC: alu_op and alu_src are driven per the opcode map.
  - R-type, ADDI, COMPI: next state WB.
  - LW, SW: next state MEM.
  - BZ: if zero=1 then pc_write=1, pc_src=01. Always instr_done=1, next state FETCH.
  - BR: pc_write=1, pc_src=10, instr_done=1, next state FETCH.
- MEM: iord=1, alu_op=000 held. LW drives mem_read=1; SW drives mem_write=1.
  - On mem_ready=1: LW goes to WB; SW asserts instr_done=1 and goes to FETCH.
  - Otherwise stay in MEM.
- WB: reg_write=1, mem_to_reg=1 for LW and 0 otherwise, instr_done=1, next state FETCH. Always exactly one cycle.
- Timeout (FETCH and MEM only):
  - wait_cnt clears on entering either state and whenever mem_ready=1.
  - It increments on each cycle spent in FETCH or MEM with mem_ready=0.
  - If WAIT_LIMIT!=0 and wait_cnt==WAIT_LIMIT-1 with mem_ready=0, next state is HALT and error<=1.
  - When WAIT_LIMIT=15, the FSM waits 15 cycles and traps at the end of the 15th.
  - mem_ready=1 on the limit cycle completes normally; completion wins.
  - wait_cnt width is clog2(WAIT_LIMIT+1), minimum 1 bit.
- HALT: halted=1 and all other strobes are 0. The state is held until rst; error is held.
- Latency per instruction, with mem_ready tied to 1:
  - R-type, ADDI, COMPI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BZ, BR: 3 cycles
  - instr_done is never asserted in FETCH or DECODE.

Test Plan:
- rst=1 for 2 cycles, then opcode=6'h00, mem_ready=1 → all outputs 0 during reset. Then FETCH (mem_read=1, ir_write=1), DECODE, EXEC (alu_op=111, alu_src=0), WB (reg_write=1, instr_done=1): 4 cycles, then back to FETCH.
- LW (6'h10), mem_ready low for 3 cycles in MEM → MEM is held 4 cycles with iord=1 and mem_read=1. WB follows with mem_to_reg=1. instr_done fires exactly once.
- BZ (6'h20), zero=1 → EXEC shows alu_op=010, pc_write=1, pc_src=01, instr_done=1. Repeat with zero=0 → pc_write=0 in EXEC.
- mem_ready stuck at 0 in FETCH with WAIT_LIMIT=15 → halted=1 and error=1 after 15 FETCH cycles; no ir_write is ever seen. Second case: mem_ready=1 exactly on the 15th cycle → normal DECODE, error=0.
- opcode=6'h3F → halted=1, error=0. opcode=6'h15 → halted=1, error=1. In both cases rst=1 for 1 cycle returns the FSM to FETCH with error=0.
- SW (6'h11) with rst asserted while in MEM → mem_write drops to 0 in the reset cycle; the next cycle is FETCH and no instr_done is issued.

Source files
------------

// File: rtl/kgp_multicycle_ctrl.sv
// KGPMini multi-cycle main control FSM.
// Sequences fetch/decode/exec/mem/writeback with a memory-wait timeout trap.
module kgp_multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       halted,
    output logic       error
);

    localparam int unsigned CW =
        (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIM_M1 =
        CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
    localparam logic TIMEOUT_EN = (WAIT_LIMIT != 0);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_COMPI = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h10;
    localparam logic [5:0] OP_SW    = 6'h11;
    localparam logic [5:0] OP_BZ    = 6'h20;
    localparam logic [5:0] OP_BR    = 6'h21;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BZ  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          error_q, error_d;

    logic is_r, is_addi, is_compi, is_lw, is_sw;
    logic is_bz, is_br, is_halt, is_legal;
    logic wait_fail;
    logic [CW-1:0] wait_next;

    always_comb begin
        is_r     = (opcode == OP_R);
        is_addi  = (opcode == OP_ADDI);
        is_compi = (opcode == OP_COMPI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_bz    = (opcode == OP_BZ);
        is_br    = (opcode == OP_BR);
        is_halt  = (opcode == OP_HALT);
        is_legal = is_r | is_addi | is_compi | is_lw
                 | is_sw | is_bz | is_br;
    end

    // Completion wins over the trap: the trap needs mem_ready low.
    always_comb begin
        wait_fail = TIMEOUT_EN && (wait_cnt_q == LIM_M1) && !mem_ready;
        wait_next = mem_ready ? '0 : wait_cnt_q + CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        error_d    = error_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = 3'b000;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        error      = error_q;

        unique case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                wait_cnt_d = wait_next;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_fail) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (!is_legal) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_r: begin
                        alu_op  = 3'b111;
                        state_d = S_WB;
                    end
                    is_addi: begin
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    is_compi: begin
                        alu_op  = 3'b001;
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    is_lw, is_sw: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    is_bz: begin
                        alu_op     = 3'b010;
                        pc_write   = zero;
                        pc_src     = zero ? PC_BZ : PC_INC;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    is_br: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_JMP;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    // IR changed under us after decode: treat as illegal.
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                iord       = 1'b1;
                mem_read   = is_lw;
                mem_write  = !is_lw;
                wait_cnt_d = wait_next;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (wait_fail) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            {ir_write, pc_write, pc_src, iord, mem_read, mem_write} = '0;
            {alu_op, alu_src, reg_write, mem_to_reg} = '0;
            {instr_done, halted, error} = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Randomised scoreboard bench for kgp_multicycle_ctrl.
// An instruction-level model queues the expected per-cycle outputs.
module tb_kgp_multicycle_ctrl;

    localparam int LIMIT = 15;

    localparam logic [15:0] IRW    = 16'h8000;
    localparam logic [15:0] PCW    = 16'h4000;
    localparam logic [15:0] SRC_J  = 16'h2000;
    localparam logic [15:0] SRC_BR = 16'h1000;
    localparam logic [15:0] IORD   = 16'h0800;
    localparam logic [15:0] MRD    = 16'h0400;
    localparam logic [15:0] MWR    = 16'h0200;
    localparam logic [15:0] ALU1   = 16'h0040;
    localparam logic [15:0] ALU2   = 16'h0080;
    localparam logic [15:0] ALU7   = 16'h01C0;
    localparam logic [15:0] ASRC   = 16'h0020;
    localparam logic [15:0] RW     = 16'h0010;
    localparam logic [15:0] M2R    = 16'h0008;
    localparam logic [15:0] DONE   = 16'h0004;
    localparam logic [15:0] HLT    = 16'h0002;
    localparam logic [15:0] ERR    = 16'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, iord, mem_read, mem_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src, reg_write, mem_to_reg;
    logic       instr_done, halted, error;
    logic [15:0] got;

    kgp_multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    assign got = {ir_write, pc_write, pc_src, iord, mem_read, mem_write,
                  alu_op, alu_src, reg_write, mem_to_reg,
                  instr_done, halted, error};

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int dut_done = 0;
    bit m_halted = 0;
    bit m_err = 0;

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h01, 6'h02, 6'h10,
                          6'h11, 6'h20, 6'h21};
    endfunction

    function automatic logic [15:0] exec_vec(input logic [5:0] op,
                                             input bit z);
        case (op)
            6'h00:        return ALU7;
            6'h01:        return ASRC;
            6'h02:        return ALU1 | ASRC;
            6'h10, 6'h11: return ASRC;
            6'h20:        return ALU2 | DONE | (z ? (PCW | SRC_BR) : 16'h0);
            default:      return PCW | SRC_J | DONE;
        endcase
    endfunction

    task automatic step(input bit r, input logic [5:0] op, input bit z,
                        input bit mr, input logic [15:0] e,
                        input string tag);
        @(posedge clk);
        #1;
        rst = r;
        opcode = op;
        zero = z;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (e[2]) exp_done++;
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, rop(), rb(), rb(), 16'h0, "reset");
        m_halted = 0;
        m_err = 0;
    endtask

    // A wait phase traps after LIMIT unready cycles.
    task automatic wait_phase(input bit fetch, input logic [5:0] op,
                              input int waits, input logic [15:0] e,
                              input string tag, output bit trapped);
        bit trap;
        int n;
        trap = (LIMIT != 0) && (waits >= LIMIT);
        n = trap ? LIMIT : waits;
        for (int i = 0; i < n; i++)
            step(1'b0, fetch ? rop() : op, rb(), 1'b0, e, tag);
        if (trap) begin
            m_halted = 1;
            m_err = 1;
        end
        trapped = trap;
    endtask

    task automatic run_instr(input logic [5:0] op, input bit z,
                             input int fw, input int mw,
                             input int rst_mem);
        bit trapped;
        logic [15:0] mb;
        wait_phase(1'b1, op, fw, MRD, "fetch_wait", trapped);
        if (trapped) return;
        step(1'b0, rop(), rb(), 1'b1, MRD | IRW | PCW, "fetch");
        step(1'b0, op, rb(), rb(), 16'h0, "decode");
        if (op == 6'h3F) begin
            m_halted = 1;
            return;
        end
        if (!legal(op)) begin
            m_halted = 1;
            m_err = 1;
            return;
        end
        step(1'b0, op, z, rb(), exec_vec(op, z), "exec");
        if (op == 6'h20 || op == 6'h21) return;
        if (op == 6'h10 || op == 6'h11) begin
            mb = IORD | ((op == 6'h10) ? MRD : MWR);
            if (rst_mem >= 0) begin
                for (int i = 0; i < rst_mem; i++)
                    step(1'b0, op, rb(), 1'b0, mb, "mem_pre_rst");
                do_reset(1);
                return;
            end
            wait_phase(1'b0, op, mw, mb, "mem_wait", trapped);
            if (trapped) return;
            if (op == 6'h11) begin
                step(1'b0, op, rb(), 1'b1, mb | DONE, "mem_sw");
                return;
            end
            step(1'b0, op, rb(), 1'b1, mb, "mem_lw");
        end
        step(1'b0, op, rb(), rb(),
             RW | DONE | ((op == 6'h10) ? M2R : 16'h0), "wb");
    endtask

    task automatic post_halt();
        if (m_halted) begin
            repeat ($urandom_range(1, 3))
                step(1'b0, rop(), rb(), rb(),
                     HLT | (m_err ? ERR : 16'h0), "halt");
            do_reset(1);
        end
    endtask

    function automatic int rwait();
        if ($urandom_range(0, 9) == 0) return $urandom_range(13, 17);
        return $urandom_range(0, 3);
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] ops[7] = '{6'h00, 6'h01, 6'h02, 6'h10,
                               6'h11, 6'h20, 6'h21};
        logic [5:0] o;
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0) return 6'h3F;
        if (sel == 1) begin
            o = rop();
            while (legal(o) || o == 6'h3F) o = rop();
            return o;
        end
        return ops[$urandom_range(0, 6)];
    endfunction

    initial begin : monitor
        logic [15:0] e;
        string t;
        forever begin
            @(negedge clk);
            if (instr_done) dut_done++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s at %0t: got %h expected %h",
                             t, $time, got, e);
                end
            end
        end
    end

    initial begin : driver
        logic [5:0] op;
        int rm;
        do_reset(2);
        run_instr(6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h10, 1'b0, 0, 3, -1);
        run_instr(6'h20, 1'b1, 0, 0, -1);
        run_instr(6'h20, 1'b0, 0, 0, -1);
        run_instr(6'h00, 1'b0, 15, 0, -1);
        post_halt();
        run_instr(6'h01, 1'b0, 14, 0, -1);
        run_instr(6'h3F, 1'b0, 0, 0, -1);
        post_halt();
        run_instr(6'h15, 1'b0, 0, 0, -1);
        post_halt();
        run_instr(6'h11, 1'b0, 0, 5, 2);
        run_instr(6'h02, 1'b0, 0, 0, -1);
        run_instr(6'h10, 1'b0, 1, 15, -1);
        post_halt();
        run_instr(6'h11, 1'b0, 2, 14, -1);
        run_instr(6'h21, 1'b0, 0, 0, -1);

        for (int k = 0; k < 250; k++) begin
            op = rand_op();
            rm = -1;
            if ((op == 6'h10 || op == 6'h11) && $urandom_range(0, 14) == 0)
                rm = $urandom_range(0, 2);
            run_instr(op, rb(), rwait(), rwait(), rm);
            post_halt();
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0",
                     exp_q.size());
        end
        checks++;
        if (dut_done != exp_done) begin
            errors++;
            $display("FAIL instr_done_count: got %0d expected %0d",
                     dut_done, exp_done);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
